// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional launch timeout (ERR pulse) is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            ACK,
    output logic                          ERR,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          PAR_EN,
    output logic                          Data_Valid,
    input  logic                          tx_busy,
    output logic                          arb_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] FRAME = 2'd2;
    logic [1:0]            state;
    logic [NUM_REQ-1:0]    last, eff, hi, src, pick;
    logic [DATA_WIDTH-1:0] dsel;
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign ERR = 1'b0;
`endif
    // last is the previous winner as a one-hot; hi keeps only requests strictly above it
    always_comb begin
        eff  = REQ & ~ACK;
        hi   = eff & ~((last << 1) - NUM_REQ'(1));
        src  = (|hi) ? hi : eff;
        pick = src & (~src + NUM_REQ'(1));
        dsel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            dsel = dsel | (REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pick[i]}});
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last       <= NUM_REQ'(1) << (NUM_REQ - 1);
            GNT        <= '0;
            ACK        <= '0;
            P_DATA     <= '0;
            PAR_EN     <= 1'b0;
            Data_Valid <= 1'b0;
            arb_busy   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            ERR        <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
            ACK        <= '0;
            Data_Valid <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            ERR        <= 1'b0;
`endif
            case (state)
                IDLE: if (|pick) begin
                    GNT        <= pick;
                    P_DATA     <= dsel;
                    PAR_EN     <= |(REQ_PAR_EN & pick);
                    Data_Valid <= 1'b1;
                    arb_busy   <= 1'b1;
                    state      <= START;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
`ifdef UART_ARB_TIMEOUT_EN
                START: if (tx_busy) state <= FRAME;
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    ERR      <= 1'b1;
                    GNT      <= '0;
                    last     <= GNT;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end else cnt <= cnt + CW'(1);
`else
                START: if (tx_busy) state <= FRAME;
`endif
                FRAME: if (!tx_busy) begin
                    ACK      <= GNT;
                    GNT      <= '0;
                    last     <= GNT;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
